tag_slot_sched: RTL
===================

TAG_SLOT_SCHED -- requirements
Module: tag_slot_sched

Interface
REQ-001 Parameter SLOT_LEN, default 262144: input samples per location slot; minimum 2.
REQ-002 Parameter NGUARD, default 64: samples skipped between preamble peak and slot 0; minimum 1.
REQ-003 Parameter TIMEOUT, default 1048576: samples waited for a peak before a timeout pulse; minimum 2.
REQ-004 Parameter NSLOT_WIDTH, default 4: width of the slot count and slot index.
REQ-005 Parameter CNT_WIDTH, default 24: width of internal sample counters; holds max(SLOT_LEN, NGUARD, TIMEOUT).
REQ-006 Port clk, input, 1: single clock for all logic.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port run, input, 1: enable; low forces IDLE.
REQ-009 Port in_tvalid, input, 1: sample strobe; all counting advances only on cycles with in_tvalid high.
REQ-010 Port peak_stb, input, 1: preamble-detector peak flag, qualified by in_tvalid.
REQ-011 Port cfg_nslots, input, NSLOT_WIDTH: slots per frame.
REQ-012 Port slot_active, output, 1: high while in SLOT.
REQ-013 Port slot_start, output, 1: one-cycle pulse on the first cycle of each slot.
REQ-014 Port slot_idx, output, NSLOT_WIDTH: current slot number.
REQ-015 Port frame_done, output, 1: one-cycle pulse at frame end.
REQ-016 Port timeout, output, 1: one-cycle pulse on wait expiry.
REQ-017 Port frame_count, output, 16: completed frames, wraps at 2^16.
REQ-018 Port sched_state, output, 3: encoded state, IDLE=0, ARMED=1, GUARD=2, SLOT=3, DONE=4.

Function
REQ-019 All outputs are registered.
REQ-020 IDLE: the block moves to ARMED on the cycle after run is sampled high.
REQ-021 ARMED, entry: the wait counter is 0.
REQ-022 ARMED, on in_tvalid & peak_stb: next state GUARD; guard counter cleared; cfg_nslots latched, with 0 latched as 1.
REQ-023 ARMED, on in_tvalid & ~peak_stb: the wait counter increments.
REQ-024 ARMED, on the TIMEOUT-th sample with no peak: timeout pulses; the wait counter returns to 0; the state stays ARMED.
REQ-025 ARMED, peak and expiry on the same sample: the peak wins and no timeout pulse is issued.
REQ-026 GUARD: after NGUARD in_tvalid samples, next state SLOT with slot_idx=0, sample counter=0 and slot_start=1 for one cycle.
REQ-027 SLOT: slot_active=1 and the sample counter increments per in_tvalid.
REQ-028 SLOT, on the SLOT_LEN-th sample, when slot_idx < latched nslots-1: slot_idx increments, the counter clears and slot_start pulses; slot_active stays high with no gap.
REQ-029 SLOT, on the SLOT_LEN-th sample of the last slot: next state DONE and slot_active drops.
REQ-030 DONE, for one cycle: frame_done=1 and frame_count increments; next state ARMED.
REQ-031 peak_stb in GUARD, SLOT or DONE is ignored.
REQ-032 A change of cfg_nslots mid-frame has no effect until the next peak acceptance.
REQ-033 run deasserted in any state: next cycle IDLE; slot_active, slot_start, frame_done and timeout are 0; counters and slot_idx are 0; frame_count holds.
REQ-034 Cycles without in_tvalid hold all counters and the state, except the transitions from IDLE and DONE, which do not depend on in_tvalid.
REQ-035 At most one of slot_start, frame_done and timeout is high in any cycle.

Reset
REQ-036 reset high at any clock edge forces IDLE and sets all outputs and counters to 0, including frame_count and slot_idx.
REQ-037 reset takes precedence over run and all inputs.
REQ-038 reset mid-slot aborts the frame without a frame_done pulse.

Verification
REQ-039 Nominal frame (SLOT_LEN=8, NGUARD=4, cfg_nslots=3, in_tvalid constant, peak at sample 10) -> slot_start pulses 5, 13 and 21 cycles after the peak cycle; slot_active is high for 24 cycles; frame_done pulses once; frame_count=1; sched_state returns to 1.
REQ-040 Timeout (TIMEOUT=32, no peak for 70 samples) -> timeout pulses on samples 32 and 64; sched_state stays 1.
REQ-041 Throttled input (in_tvalid every 3rd cycle, cfg_nslots=1) -> slot_active spans exactly 8 valid samples (22-24 cycles); slot_idx stays 0.
REQ-042 Edge cases (cfg_nslots=0; a peak coincident with wait expiry; peak_stb pulses during SLOT) -> one slot is run for cfg_nslots=0; no timeout pulse on the coincident sample; the in-slot peaks do not disturb counts.
REQ-043 Abort (run dropped in slot 1, then reset asserted) -> IDLE the next cycle; frame_count is held after the run drop and is 0 after reset; no frame_done pulse is issued.

Source files
------------

// File: rtl/tag_slot_sched.sv
// Slot scheduler for a tag receiver: waits for a preamble peak, skips a guard
// interval, then walks through cfg_nslots fixed-length location slots per frame.
module tag_slot_sched #(
  parameter int SLOT_LEN    = 262144,
  parameter int NGUARD      = 64,
  parameter int TIMEOUT     = 1048576,
  parameter int NSLOT_WIDTH = 4,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   in_tvalid,
  input  logic                   peak_stb,
  input  logic [NSLOT_WIDTH-1:0] cfg_nslots,
  output logic                   slot_active,
  output logic                   slot_start,
  output logic [NSLOT_WIDTH-1:0] slot_idx,
  output logic                   frame_done,
  output logic                   timeout,
  output logic [15:0]            frame_count,
  output logic [2:0]             sched_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    GUARD = 3'd2,
    SLOT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] GUARD_LAST   = CNT_WIDTH'(NGUARD - 1);
  localparam logic [CNT_WIDTH-1:0] SLOT_LAST    = CNT_WIDTH'(SLOT_LEN - 1);
  localparam logic [NSLOT_WIDTH-1:0] IDX_ZERO   = {NSLOT_WIDTH{1'b0}};
  localparam logic [NSLOT_WIDTH-1:0] IDX_ONE    = NSLOT_WIDTH'(1);

  state_e                 state_r, state_nxt_s;
  logic [CNT_WIDTH-1:0]   wait_cnt_r, wait_cnt_nxt_s;
  logic [CNT_WIDTH-1:0]   guard_cnt_r, guard_cnt_nxt_s;
  logic [CNT_WIDTH-1:0]   samp_cnt_r, samp_cnt_nxt_s;
  logic [NSLOT_WIDTH-1:0] nslots_r, nslots_nxt_s;
  logic [NSLOT_WIDTH-1:0] slot_idx_r, slot_idx_nxt_s;
  logic [15:0]            frame_count_r, frame_count_nxt_s;
  logic                   slot_active_r, slot_start_r, frame_done_r, timeout_r;
  logic                   slot_start_nxt_s, frame_done_nxt_s, timeout_nxt_s;
  logic                   peak_s, wait_expire_s, guard_last_s, slot_end_s, last_slot_s;
  logic [NSLOT_WIDTH:0]   slot_num_s;

  assign peak_s        = in_tvalid & peak_stb;
  assign wait_expire_s = (wait_cnt_r == TIMEOUT_LAST);
  assign guard_last_s  = (guard_cnt_r == GUARD_LAST);
  assign slot_end_s    = (samp_cnt_r == SLOT_LAST);
  // nslots_r is never 0 while in SLOT, so "idx+1 >= nslots" marks the final slot
  assign slot_num_s    = {1'b0, slot_idx_r} + {1'b0, IDX_ONE};
  assign last_slot_s   = (slot_num_s >= {1'b0, nslots_r});

  // State and all registered outputs/counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      wait_cnt_r    <= CNT_ZERO;
      guard_cnt_r   <= CNT_ZERO;
      samp_cnt_r    <= CNT_ZERO;
      nslots_r      <= IDX_ZERO;
      slot_idx_r    <= IDX_ZERO;
      frame_count_r <= 16'd0;
      slot_active_r <= 1'b0;
      slot_start_r  <= 1'b0;
      frame_done_r  <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      guard_cnt_r   <= guard_cnt_nxt_s;
      samp_cnt_r    <= samp_cnt_nxt_s;
      nslots_r      <= nslots_nxt_s;
      slot_idx_r    <= slot_idx_nxt_s;
      frame_count_r <= frame_count_nxt_s;
      slot_active_r <= (state_nxt_s == SLOT);
      slot_start_r  <= slot_start_nxt_s;
      frame_done_r  <= frame_done_nxt_s;
      timeout_r     <= timeout_nxt_s;
    end
  end

  // Next-state decision
  always_comb begin
    state_nxt_s = state_r;
    if (!run) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:  state_nxt_s = ARMED;
        ARMED: if (peak_s) state_nxt_s = GUARD; else state_nxt_s = ARMED;
        GUARD: if (in_tvalid && guard_last_s) state_nxt_s = SLOT; else state_nxt_s = GUARD;
        SLOT: begin
          if (in_tvalid && slot_end_s && last_slot_s) state_nxt_s = DONE;
          else state_nxt_s = SLOT;
        end
        DONE:    state_nxt_s = ARMED;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Counter updates and next values of the pulse outputs
  always_comb begin
    wait_cnt_nxt_s    = wait_cnt_r;
    guard_cnt_nxt_s   = guard_cnt_r;
    samp_cnt_nxt_s    = samp_cnt_r;
    nslots_nxt_s      = nslots_r;
    slot_idx_nxt_s    = slot_idx_r;
    frame_count_nxt_s = frame_count_r;
    slot_start_nxt_s  = 1'b0;
    frame_done_nxt_s  = 1'b0;
    timeout_nxt_s     = 1'b0;
    if (!run) begin
      wait_cnt_nxt_s  = CNT_ZERO;
      guard_cnt_nxt_s = CNT_ZERO;
      samp_cnt_nxt_s  = CNT_ZERO;
      slot_idx_nxt_s  = IDX_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          wait_cnt_nxt_s  = CNT_ZERO;
          guard_cnt_nxt_s = CNT_ZERO;
          samp_cnt_nxt_s  = CNT_ZERO;
        end
        ARMED: begin
          if (peak_s) begin
            wait_cnt_nxt_s  = CNT_ZERO;
            guard_cnt_nxt_s = CNT_ZERO;
            nslots_nxt_s    = (cfg_nslots == IDX_ZERO) ? IDX_ONE : cfg_nslots;
          end else if (in_tvalid && wait_expire_s) begin
            wait_cnt_nxt_s = CNT_ZERO;
            timeout_nxt_s  = 1'b1;
          end else if (in_tvalid) begin
            wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r;
          end
        end
        GUARD: begin
          if (in_tvalid && guard_last_s) begin
            guard_cnt_nxt_s  = CNT_ZERO;
            samp_cnt_nxt_s   = CNT_ZERO;
            slot_idx_nxt_s   = IDX_ZERO;
            slot_start_nxt_s = 1'b1;
          end else if (in_tvalid) begin
            guard_cnt_nxt_s = guard_cnt_r + CNT_ONE;
          end else begin
            guard_cnt_nxt_s = guard_cnt_r;
          end
        end
        SLOT: begin
          if (in_tvalid && slot_end_s) begin
            samp_cnt_nxt_s = CNT_ZERO;
            if (last_slot_s) begin
              frame_done_nxt_s  = 1'b1;
              frame_count_nxt_s = frame_count_r + 16'd1;
            end else begin
              slot_idx_nxt_s   = slot_idx_r + IDX_ONE;
              slot_start_nxt_s = 1'b1;
            end
          end else if (in_tvalid) begin
            samp_cnt_nxt_s = samp_cnt_r + CNT_ONE;
          end else begin
            samp_cnt_nxt_s = samp_cnt_r;
          end
        end
        DONE: wait_cnt_nxt_s = CNT_ZERO;
        default: begin
          wait_cnt_nxt_s  = CNT_ZERO;
          guard_cnt_nxt_s = CNT_ZERO;
          samp_cnt_nxt_s  = CNT_ZERO;
        end
      endcase
    end
  end

  assign slot_active = slot_active_r;
  assign slot_start  = slot_start_r;
  assign slot_idx    = slot_idx_r;
  assign frame_done  = frame_done_r;
  assign timeout     = timeout_r;
  assign frame_count = frame_count_r;
  assign sched_state = state_r;

endmodule
